// File: rtl/snn_pkg.sv
// Shared defaults and decoder state encoding for the spiking-network output stage.
package snn_pkg;

    localparam int NCLS_DEFAULT    = 8;
    localparam int T_STEPS_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_e;

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of NCLS saturating per-class spike counters with a shared clear and one indexed read port.
module spike_counter_bank #(
    parameter int  NCLS  = 8,
    parameter int  CNT_W = 5,
    localparam int IDX_W = $clog2(NCLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [NCLS-1:0]  inc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_all [NCLS];

    generate
        for (genvar gi = 0; gi < NCLS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Holding at the top value keeps a long window from wrapping to a small count.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (inc[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign rd_cnt = cnt_all[rd_idx];

endmodule

// File: rtl/spike_vote_decoder.sv
// Rate-coded output decoder: counts spikes per class over a window, then scans for the winner.
// Optional reward output against a latched target label when SNN_REWARD_EN is defined.
module spike_vote_decoder
    import snn_pkg::*;
#(
    parameter int  NCLS    = NCLS_DEFAULT,
    parameter int  T_STEPS = T_STEPS_DEFAULT,
    parameter int  CNT_W   = CNT_W_DEFAULT,
    localparam int IDX_W   = $clog2(NCLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             spk_valid,
    input  logic [NCLS-1:0]  spk,
`ifdef SNN_REWARD_EN
    input  logic [IDX_W-1:0] label,
    output logic             reward_valid,
    output logic             reward,
`endif
    output logic             busy,
    output logic             pred_valid,
    output logic [IDX_W-1:0] pred_class,
    output logic [CNT_W-1:0] pred_count,
    output logic             pred_none
);

    generate
        if (T_STEPS < 1 || T_STEPS > (2 ** CNT_W) - 1) begin : g_bad_t_steps
            $error("spike_vote_decoder: T_STEPS must lie in 1..2^CNT_W-1");
        end
        if (NCLS < 2 || NCLS > 16) begin : g_bad_ncls
            $error("spike_vote_decoder: NCLS must lie in 2..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(T_STEPS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCLS - 1);

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0] pred_class_q, pred_class_d;
    logic [CNT_W-1:0] pred_count_q, pred_count_d;
    logic             pred_none_q, pred_none_d;

    logic             bank_clr;
    logic [NCLS-1:0]  bank_inc;
    logic [CNT_W-1:0] rd_cnt;
    logic [IDX_W-1:0] cand_idx;
    logic [CNT_W-1:0] cand_cnt;

    spike_counter_bank #(
        .NCLS  (NCLS),
        .CNT_W (CNT_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .clr    (bank_clr),
        .inc    (bank_inc),
        .rd_idx (scan_q),
        .rd_cnt (rd_cnt)
    );

    // Strictly-greater replacement makes ties fall to the lowest index.
    always_comb begin
        cand_idx = best_idx_q;
        cand_cnt = best_cnt_q;
        if (rd_cnt > best_cnt_q) begin
            cand_idx = scan_q;
            cand_cnt = rd_cnt;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        scan_d       = scan_q;
        best_idx_d   = best_idx_q;
        best_cnt_d   = best_cnt_q;
        pred_class_d = pred_class_q;
        pred_count_d = pred_count_q;
        pred_none_d  = pred_none_q;
        bank_clr     = 1'b0;
        bank_inc     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bank_clr = 1'b1;
                    step_d   = '0;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (spk_valid) begin
                    bank_inc = spk;
                    step_d   = step_q + CNT_W'(1);
                    if (step_q == LAST_STEP) begin
                        scan_d     = '0;
                        best_idx_d = '0;
                        best_cnt_d = '0;
                        state_d    = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                best_idx_d = cand_idx;
                best_cnt_d = cand_cnt;
                scan_d     = scan_q + IDX_W'(1);
                // Result registers load here so they are already valid in the DONE cycle.
                if (scan_q == LAST_IDX) begin
                    pred_class_d = cand_idx;
                    pred_count_d = cand_cnt;
                    pred_none_d  = (cand_cnt == '0);
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            scan_q       <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            pred_class_q <= '0;
            pred_count_q <= '0;
            pred_none_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            scan_q       <= scan_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            pred_class_q <= pred_class_d;
            pred_count_q <= pred_count_d;
            pred_none_q  <= pred_none_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign pred_valid = (state_q == ST_DONE);
    assign pred_class = pred_class_q;
    assign pred_count = pred_count_q;
    assign pred_none  = pred_none_q;

`ifdef SNN_REWARD_EN
    logic [IDX_W-1:0] label_q, label_d;

    always_comb begin
        label_d = label_q;
        if ((state_q == ST_IDLE) && start) begin
            label_d = label;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            label_q <= '0;
        end else begin
            label_q <= label_d;
        end
    end

    assign reward_valid = (state_q == ST_DONE);
    assign reward       = reward_valid && (pred_class_q == label_q) && !pred_none_q;
`endif

endmodule

// File: tb/tb_spike_vote_decoder.sv
// Scoreboard bench for spike_vote_decoder: instance A uses defaults, instance B uses T_STEPS=31.
// Reward outputs are checked only when SNN_REWARD_EN is defined.
module tb_spike_vote_decoder;

    localparam int NC = 8;

    typedef struct {
        int cls;
        int cnt;
        int none;
        int rew;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, spk_valid_a, start_b, spk_valid_b;
    logic [7:0] spk_a, spk_b;
    logic [2:0] label_a, label_b;
    logic       busy_a, pred_valid_a, pred_none_a;
    logic       busy_b, pred_valid_b, pred_none_b;
    logic [2:0] pred_class_a, pred_class_b;
    logic [4:0] pred_count_a, pred_count_b;
`ifdef SNN_REWARD_EN
    logic       reward_valid_a, reward_a, reward_valid_b, reward_b;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   mcnt_a[NC];
    int   lat_a, last_a, lat_b, last_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spike_vote_decoder #(.NCLS(8), .T_STEPS(16), .CNT_W(5)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start_a),
        .spk_valid    (spk_valid_a),
        .spk          (spk_a),
`ifdef SNN_REWARD_EN
        .label        (label_a),
        .reward_valid (reward_valid_a),
        .reward       (reward_a),
`endif
        .busy         (busy_a),
        .pred_valid   (pred_valid_a),
        .pred_class   (pred_class_a),
        .pred_count   (pred_count_a),
        .pred_none    (pred_none_a)
    );

    spike_vote_decoder #(.NCLS(8), .T_STEPS(31), .CNT_W(5)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start_b),
        .spk_valid    (spk_valid_b),
        .spk          (spk_b),
`ifdef SNN_REWARD_EN
        .label        (label_b),
        .reward_valid (reward_valid_b),
        .reward       (reward_b),
`endif
        .busy         (busy_b),
        .pred_valid   (pred_valid_b),
        .pred_class   (pred_class_b),
        .pred_count   (pred_count_b),
        .pred_none    (pred_none_b)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A stimulus and model ----------------
    task automatic start_win_a(input int lbl);
        label_a = 3'(lbl);
        lat_a   = lbl;
        for (int i = 0; i < NC; i++) mcnt_a[i] = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic step_a(input logic [7:0] s);
        spk_valid_a = 1'b1;
        spk_a       = s;
        last_a      = cyc;
        for (int i = 0; i < NC; i++) begin
            if (s[i] && mcnt_a[i] < 31) mcnt_a[i]++;
        end
        tick();
        spk_valid_a = 1'b0;
        spk_a       = 8'($urandom);
    endtask

    task automatic finish_a;
        exp_t e;
        int   bc = 0;
        int   bi = 0;
        for (int i = 0; i < NC; i++) begin
            if (mcnt_a[i] > bc) begin
                bc = mcnt_a[i];
                bi = i;
            end
        end
        e.cls  = bi;
        e.cnt  = bc;
        e.none = (bc == 0) ? 1 : 0;
        e.rew  = (bi == lat_a && bc != 0) ? 1 : 0;
        e.cyc  = last_a + NC + 1;
        q_a.push_back(e);
    endtask

    task automatic drain_a;
        for (int i = 0; i < 40; i++) begin
            if (q_a.size() == 0) break;
            @(negedge clk);
        end
        check("a_drain", q_a.size(), 0);
        tick();
    endtask

    task automatic step_b(input logic [7:0] s, input logic st);
        spk_valid_b = 1'b1;
        spk_b       = s;
        start_b     = st;
        last_b      = cyc;
        tick();
        spk_valid_b = 1'b0;
        start_b     = 1'b0;
        spk_b       = 8'($urandom);
    endtask

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (pred_valid_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_pred", 1, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                $display("pred A: class=%0d count=%0d none=%0d cycle=%0d", pred_class_a, pred_count_a, pred_none_a, cyc);
                check("a_class", int'(pred_class_a), e.cls);
                check("a_count", int'(pred_count_a), e.cnt);
                check("a_none", int'(pred_none_a), e.none);
                check("a_latency", cyc, e.cyc);
`ifdef SNN_REWARD_EN
                check("a_reward_valid", int'(reward_valid_a), 1);
                check("a_reward", int'(reward_a), e.rew);
`endif
            end
        end
        if (pred_valid_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_pred", 1, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                $display("pred B: class=%0d count=%0d none=%0d cycle=%0d", pred_class_b, pred_count_b, pred_none_b, cyc);
                check("b_class", int'(pred_class_b), e.cls);
                check("b_count", int'(pred_count_b), e.cnt);
                check("b_none", int'(pred_none_b), e.none);
                check("b_latency", cyc, e.cyc);
`ifdef SNN_REWARD_EN
                check("b_reward", int'(reward_b), e.rew);
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        exp_t eb;
        bit   seen;
        rst = 1'b1;
        start_a = 1'b0; spk_valid_a = 1'b0; spk_a = '0; label_a = '0;
        start_b = 1'b0; spk_valid_b = 1'b0; spk_b = '0; label_b = '0;
        tick();
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_pv_a", int'(pred_valid_a), 0);
        check("rst_class_a", int'(pred_class_a), 0);
        check("rst_count_a", int'(pred_count_a), 0);
        check("rst_none_a", int'(pred_none_a), 0);
        check("rst_busy_b", int'(busy_b), 0);
        tick();
        rst = 1'b0;
        tick();

        // single class spiking every step
        start_win_a(0);
        check("a_busy_accum", int'(busy_a), 1);
        for (int i = 0; i < 16; i++) step_a(8'h04);
        finish_a();
        drain_a();

        // tie between classes 1 and 5
        start_win_a(0);
        for (int i = 0; i < 7; i++) step_a(8'h22);
        for (int i = 0; i < 9; i++) step_a(8'h00);
        finish_a();
        drain_a();

        // silent window, valid every third cycle with junk on spk in the gaps
        start_win_a(0);
        for (int i = 0; i < 16; i++) begin
            step_a(8'h00);
            tick();
            tick();
        end
        finish_a();
        drain_a();

        // random windows
        for (int w = 0; w < 3; w++) begin
            start_win_a(w);
            for (int i = 0; i < 16; i++) step_a(8'($urandom));
            finish_a();
            drain_a();
        end

        // start during DONE is ignored
        start_win_a(0);
        for (int i = 0; i < 16; i++) step_a(8'h10);
        finish_a();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pred_valid_a) begin
                seen = 1'b1;
                break;
            end
        end
        check("a_done_seen", int'(seen), 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_start_in_done_busy", int'(busy_a), 0);
        drain_a();

        // label latched at start, changed mid-window: winner equals label
        start_win_a(3);
        for (int i = 0; i < 5; i++) step_a(8'h08);
        label_a = 3'd0;
        for (int i = 0; i < 11; i++) step_a(8'h09);
        finish_a();
        drain_a();
        // winner differs from label
        start_win_a(3);
        for (int i = 0; i < 16; i++) step_a(8'h10);
        finish_a();
        drain_a();

        // reset at step 8 aborts the window and clears held outputs
        start_win_a(0);
        for (int i = 0; i < 8; i++) step_a(8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("a_abort_busy", int'(busy_a), 0);
        check("a_abort_pv", int'(pred_valid_a), 0);
        check("a_abort_class", int'(pred_class_a), 0);
        check("a_abort_count", int'(pred_count_a), 0);
        repeat (15) tick();
        // reset wins over a simultaneous start
        rst = 1'b1;
        start_a = 1'b1;
        tick();
        rst = 1'b0;
        start_a = 1'b0;
        check("a_rst_over_start_busy", int'(busy_a), 0);
        start_win_a(6);
        for (int i = 0; i < 16; i++) step_a(8'($urandom) | 8'h40);
        finish_a();
        drain_a();

        // T_STEPS=31: class 7 every step reaches 31, second start mid-window ignored
        label_b = 3'd7;
        lat_b   = 7;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 31; i++) step_b(8'h80, i == 10);
        eb.cls  = 7;
        eb.cnt  = 31;
        eb.none = 0;
        eb.rew  = (lat_b == 7) ? 1 : 0;
        eb.cyc  = last_b + NC + 1;
        q_b.push_back(eb);
        for (int i = 0; i < 40; i++) begin
            if (q_b.size() == 0) break;
            @(negedge clk);
        end
        check("b_drain", q_b.size(), 0);
        repeat (3) tick();
        check("b_idle_after", int'(busy_b), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spike_vote_decoder.md
SPIKE_VOTE_DECODER -- requirements
Module: spike_vote_decoder

Interface
REQ-001 Parameter NCLS, default 8: number of output classes (output neurons), 2..16.
REQ-002 Parameter T_STEPS, default 16: inference window length in spike timesteps, 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 5: width of each per-class spike counter.
REQ-004 Derived IDX_W = clog2(NCLS); elaboration SHALL fail if T_STEPS < 1 or T_STEPS > 2^CNT_W-1.
REQ-005 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to open a new window.
REQ-008 spk_valid  in  1  spk carries one timestep's output spikes this cycle.
REQ-009 spk  in  NCLS  per-class spike bits from the Multilayer output layer.
REQ-010 busy  out  1  high in every state other than IDLE.
REQ-011 pred_valid  out  1  one-cycle pulse marking a completed prediction.
REQ-012 pred_class  out  IDX_W  winning class index, held until the next pred_valid.
REQ-013 pred_count  out  CNT_W  spike count of the winning class, held.
REQ-014 pred_none  out  1  no class spiked in the window, held.
REQ-015 label  in  IDX_W  target class; present only when SNN_REWARD_EN is defined.
REQ-016 reward_valid, reward  out  1 each; present only when SNN_REWARD_EN is defined.

Function
REQ-017 FSM states: IDLE, ACCUM, SCAN, DONE.
REQ-018 IDLE + start: clear all counters and the step counter, go to ACCUM; start in any other state SHALL be ignored.
REQ-019 ACCUM: on each spk_valid cycle, increment cnt[i] for each spk[i]=1 and increment the step counter; spk SHALL be ignored when spk_valid=0.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 When the T_STEPS-th spk_valid is accepted (cycle c), go to SCAN at c+1.
REQ-022 SCAN: examine one class per cycle, index 0..NCLS-1, during cycles c+1..c+NCLS; replace the running best only on a strictly greater count, so ties resolve to the lowest index.
REQ-023 DONE occupies cycle c+NCLS+1: pred_valid=1, outputs updated in the same cycle, return to IDLE at c+NCLS+2.
REQ-024 All counts zero: pred_class=0, pred_count=0, pred_none=1.
REQ-025 spk_valid during SCAN or DONE SHALL be dropped without effect.
REQ-026 start arriving in the DONE cycle SHALL be ignored; the earliest accepted start is in the first IDLE cycle.

Reset
REQ-027 rst SHALL force IDLE and clear all counters; busy, pred_valid, pred_class, pred_count, pred_none, reward_valid and reward SHALL all be 0 in the cycle after rst is sampled high.
REQ-028 rst asserted mid-ACCUM or mid-SCAN SHALL abort the window with no pred_valid.
REQ-029 rst has priority over start.

Configuration
REQ-030 Macro SNN_REWARD_EN defined: label SHALL be latched on the accepted start; in DONE, reward_valid=1 and reward=(pred_class==latched label) && !pred_none.
REQ-031 Macro SNN_REWARD_EN undefined: the label, reward_valid and reward ports and the label register SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-032 Shared package snn_pkg SHALL hold the defaults for NCLS, T_STEPS and CNT_W, plus the decoder state enum.
REQ-033 Sub-module spike_counter_bank SHALL contain the NCLS saturating counters (clear, inc vector, indexed read port); the FSM and argmax scan stay in spike_vote_decoder.

Verification
REQ-034 Defaults; start; 16 steps with spk=8'b0000_0100 every step -> pred_valid exactly 9 cycles after the 16th step, pred_class=2, pred_count=16, pred_none=0.
REQ-035 16 steps, classes 1 and 5 each spiking 7 times, all others 0 -> pred_class=1 (tie goes to lowest index), pred_count=7.
REQ-036 16 steps with spk=0; spk_valid gapped to every 3rd cycle -> pred_class=0, pred_count=0, pred_none=1, pred_valid after exactly 16 accepted steps.
REQ-037 CNT_W=5, T_STEPS=31, class 7 always spiking -> pred_count=31 with no wrap; a second start pulsed during ACCUM changes nothing.
REQ-038 rst asserted at step 8 -> busy=0 the next cycle, no pred_valid; a fresh window afterwards predicts correctly.
REQ-039 SNN_REWARD_EN defined; label=3 latched at start, label changed to 0 mid-window, class 3 wins -> reward_valid=1, reward=1; repeat with class 4 winning -> reward=0.
